ptp_rx_proc: RTL and testbench

- Receive-side counterpart of the PTP transmit engine.
- Consumes 134-bit flit streams from the MAC receive path and parses PTP sync, delay-request, delay-response and test frames. Extracts ingress timestamp, origin timestamp and peer key.
- Hands per-message events to PTP_CTRL and the transmit engine: key FIFO feed, ts_4 feed, send triggers.
- Drops malformed frames and frames that are not PTP, and counts them.

---
 rtl/ptp_rx_proc_if.sv | 25 ++
 rtl/ptp_rx_proc.sv | 254 +++++++++++++++++++++++++
 tb/tb_ptp_rx_proc.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ptp_rx_proc_if.sv
// Flit stream from the MAC receive path into ptp_rx_proc: flit strobe/data,
// end-of-frame status strobe and the parser's ready back-pressure.
interface ptp_rx_proc_if;
  logic         in_data_wr;
  logic [133:0] in_data;
  logic         in_valid_wr;
  logic         in_valid;
  logic         in_ready;

  modport master (
    output in_data_wr,
    output in_data,
    output in_valid_wr,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data_wr,
    input  in_data,
    input  in_valid_wr,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/ptp_rx_proc.sv
// Receive-side PTP parser: extracts timestamps/peer key from 6-flit frames and emits events.
// Define PTP_RX_DMAC_FILTER_EN to accept only frames addressed to MAC_ADDR or broadcast.
module ptp_rx_proc #(
  parameter logic [15:0] ETHERTYPE = 16'h88F7,
  parameter int unsigned PKT_FLITS = 6,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  ptp_rx_proc_if.slave      rx,
  input  logic [47:0]       MAC_ADDR,
  output logic [3:0]        ptp_rcv_type,
  output logic              ptp_rcv_type_valid,
  output logic [53:0]       key,
  output logic              key_valid,
  output logic [47:0]       ts_4,
  output logic              ts_4_valid,
  output logic [47:0]       t1_ts,
  output logic [47:0]       t2_ts,
  output logic              sync_ts_valid,
  output logic [47:0]       t4_ts,
  output logic              resp_ts_valid,
  output logic [CNT_W-1:0]  rx_sync_cnt,
  output logic [CNT_W-1:0]  rx_req_cnt,
  output logic [CNT_W-1:0]  rx_resp_cnt,
  output logic [CNT_W-1:0]  rx_err_cnt,
  output logic [CNT_W-1:0]  rx_drop_cnt
);

  localparam int unsigned     FCNT_W     = $clog2(PKT_FLITS + 1);
  localparam logic [FCNT_W-1:0] LAST_MID = FCNT_W'(PKT_FLITS - 2);
  localparam logic [FCNT_W-1:0] FIRST_BODY = FCNT_W'(3);
  localparam logic [15:0] MSG_SYNC = 16'h0101;
  localparam logic [15:0] MSG_REQ  = 16'h0301;
  localparam logic [15:0] MSG_RESP = 16'h0401;
  localparam logic [15:0] MSG_TEST = 16'h0501;

  typedef enum logic [2:0] {S_IDLE, S_META2, S_ETH, S_BODY, S_TAIL, S_STAT} state_e;

  state_e            r_state, w_state_nxt;
  logic [FCNT_W-1:0] r_fcnt, w_fcnt_nxt;
  logic              r_ready;
  logic [5:0]        r_port;
  logic [47:0]       r_ingress, r_smac, r_origin;
  logic [15:0]       r_etype, r_msg;
  logic              r_dmac_ok;

  logic [3:0]        r_type;
  logic              r_type_valid, r_key_valid, r_ts4_valid, r_sync_valid, r_resp_valid;
  logic [53:0]       r_key;
  logic [47:0]       r_ts4, r_t1, r_t2, r_t4;
  logic [CNT_W-1:0]  r_sync_cnt, r_req_cnt, r_resp_cnt, r_err_cnt, r_drop_cnt;

  logic w_head, w_mid, w_tail;
  logic w_latch_head, w_latch_eth, w_latch_tail, w_len_err, w_eval;
  logic w_dmac_ok, w_msg_ok, w_frame_ok, w_accept, w_drop, w_err_inc;
  logic [47:0] w_origin;
  logic w_unused;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    w_head = rx.in_data_wr & (rx.in_data[133:132] == 2'b01);
    w_mid  = rx.in_data_wr & (rx.in_data[133:132] == 2'b11);
    w_tail = rx.in_data_wr & (rx.in_data[133:132] == 2'b10);
  end

`ifdef PTP_RX_DMAC_FILTER_EN
  always_comb w_dmac_ok = (rx.in_data[127:80] == MAC_ADDR) | (&rx.in_data[127:80]);
`else
  always_comb w_dmac_ok = 1'b1;
`endif

  assign w_unused = ^{rx.in_data[131:128], MAC_ADDR};

  always_comb begin
    w_state_nxt  = r_state;
    w_fcnt_nxt   = r_fcnt;
    w_latch_head = 1'b0;
    w_latch_eth  = 1'b0;
    w_latch_tail = 1'b0;
    w_len_err    = 1'b0;
    w_eval       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_head) begin
          w_latch_head = 1'b1;
          w_state_nxt  = S_META2;
        end else if (w_mid || w_tail) begin
          w_len_err = 1'b1;
        end
      end
      // Flits are not accepted while in_ready is low; only the status strobe matters.
      S_STAT: begin
        if (rx.in_valid_wr) begin
          w_eval      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        if (w_head) begin
          w_len_err    = 1'b1;
          w_latch_head = 1'b1;
          w_state_nxt  = S_META2;
        end else if (w_mid) begin
          if (r_state == S_META2) begin
            w_state_nxt = S_ETH;
          end else if (r_state == S_ETH) begin
            w_latch_eth = 1'b1;
            w_fcnt_nxt  = FIRST_BODY;
            w_state_nxt = S_BODY;
          end else if (r_state == S_BODY) begin
            if (r_fcnt == LAST_MID) w_state_nxt = S_TAIL;
            else                    w_fcnt_nxt  = r_fcnt + 1'b1;
          end else begin
            w_len_err   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_tail) begin
          if (r_state == S_TAIL) begin
            w_latch_tail = 1'b1;
            if (rx.in_valid_wr) begin
              w_eval      = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_STAT;
            end
          end else begin
            w_len_err   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
    endcase
  end

  // Same-cycle tail+status evaluates against the origin timestamp still on the bus.
  always_comb begin
    w_origin   = (r_state == S_TAIL) ? rx.in_data[95:48] : r_origin;
    w_msg_ok   = (r_msg == MSG_SYNC) | (r_msg == MSG_REQ) | (r_msg == MSG_RESP) |
                 (r_msg == MSG_TEST);
    w_frame_ok = (r_etype == ETHERTYPE) & w_msg_ok & r_dmac_ok;
    w_accept   = w_eval & rx.in_valid & w_frame_ok;
    w_drop     = w_eval & rx.in_valid & ~w_frame_ok;
    w_err_inc  = w_len_err | (w_eval & ~rx.in_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_fcnt    <= '0;
      r_ready   <= 1'b0;
      r_port    <= '0;
      r_ingress <= '0;
      r_smac    <= '0;
      r_etype   <= '0;
      r_msg     <= '0;
      r_dmac_ok <= 1'b0;
      r_origin  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_ready <= (w_state_nxt != S_STAT);
      if (w_latch_head) begin
        r_port    <= rx.in_data[125:120];
        r_ingress <= rx.in_data[47:0];
      end
      if (w_latch_eth) begin
        r_smac    <= rx.in_data[79:32];
        r_etype   <= rx.in_data[31:16];
        r_msg     <= rx.in_data[15:0];
        r_dmac_ok <= w_dmac_ok;
      end
      if (w_latch_tail) r_origin <= rx.in_data[95:48];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type       <= '0;
      r_type_valid <= 1'b0;
      r_key        <= '0;
      r_key_valid  <= 1'b0;
      r_ts4        <= '0;
      r_ts4_valid  <= 1'b0;
      r_t1         <= '0;
      r_t2         <= '0;
      r_sync_valid <= 1'b0;
      r_t4         <= '0;
      r_resp_valid <= 1'b0;
      r_sync_cnt   <= '0;
      r_req_cnt    <= '0;
      r_resp_cnt   <= '0;
      r_err_cnt    <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_type_valid <= 1'b0;
      r_key_valid  <= 1'b0;
      r_ts4_valid  <= 1'b0;
      r_sync_valid <= 1'b0;
      r_resp_valid <= 1'b0;
      if (w_err_inc) r_err_cnt  <= sat_inc(r_err_cnt);
      if (w_drop)    r_drop_cnt <= sat_inc(r_drop_cnt);
      if (w_accept) begin
        r_type       <= r_msg[11:8];
        r_type_valid <= 1'b1;
        case (r_msg)
          MSG_SYNC: begin
            r_key        <= {r_smac, r_port};
            r_key_valid  <= 1'b1;
            r_t1         <= w_origin;
            r_t2         <= r_ingress;
            r_sync_valid <= 1'b1;
            r_sync_cnt   <= sat_inc(r_sync_cnt);
          end
          MSG_REQ: begin
            r_key       <= {r_smac, r_port};
            r_key_valid <= 1'b1;
            r_ts4       <= r_ingress;
            r_ts4_valid <= 1'b1;
            r_req_cnt   <= sat_inc(r_req_cnt);
          end
          MSG_RESP: begin
            r_t4         <= w_origin;
            r_resp_valid <= 1'b1;
            r_resp_cnt   <= sat_inc(r_resp_cnt);
          end
          default: ;
        endcase
      end
    end
  end

  assign rx.in_ready          = r_ready;
  assign ptp_rcv_type         = r_type;
  assign ptp_rcv_type_valid   = r_type_valid;
  assign key                  = r_key;
  assign key_valid            = r_key_valid;
  assign ts_4                 = r_ts4;
  assign ts_4_valid           = r_ts4_valid;
  assign t1_ts                = r_t1;
  assign t2_ts                = r_t2;
  assign sync_ts_valid        = r_sync_valid;
  assign t4_ts                = r_t4;
  assign resp_ts_valid        = r_resp_valid;
  assign rx_sync_cnt          = r_sync_cnt;
  assign rx_req_cnt           = r_req_cnt;
  assign rx_resp_cnt          = r_resp_cnt;
  assign rx_err_cnt           = r_err_cnt;
  assign rx_drop_cnt          = r_drop_cnt;

endmodule

// File: tb/tb_ptp_rx_proc.sv
// Randomized self-checking bench for ptp_rx_proc against a frame-level model,
// plus directed frames with literal expectations.
module tb_ptp_rx_proc;
  localparam int unsigned CW  = 4;
  localparam int unsigned PKT = 6;
  localparam logic [15:0] ET  = 16'h88F7;
  localparam logic [47:0] MY_MAC = 48'h02005E102030;
  localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ptp_rx_proc_if rx ();
  logic [47:0]   mac_addr = MY_MAC;
  logic [3:0]    ptp_rcv_type;
  logic          ptp_rcv_type_valid, key_valid, ts_4_valid, sync_ts_valid, resp_ts_valid;
  logic [53:0]   key;
  logic [47:0]   ts_4, t1_ts, t2_ts, t4_ts;
  logic [CW-1:0] rx_sync_cnt, rx_req_cnt, rx_resp_cnt, rx_err_cnt, rx_drop_cnt;

  ptp_rx_proc #(.ETHERTYPE(ET), .PKT_FLITS(PKT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .MAC_ADDR(mac_addr),
    .ptp_rcv_type(ptp_rcv_type), .ptp_rcv_type_valid(ptp_rcv_type_valid),
    .key(key), .key_valid(key_valid), .ts_4(ts_4), .ts_4_valid(ts_4_valid),
    .t1_ts(t1_ts), .t2_ts(t2_ts), .sync_ts_valid(sync_ts_valid),
    .t4_ts(t4_ts), .resp_ts_valid(resp_ts_valid),
    .rx_sync_cnt(rx_sync_cnt), .rx_req_cnt(rx_req_cnt), .rx_resp_cnt(rx_resp_cnt),
    .rx_err_cnt(rx_err_cnt), .rx_drop_cnt(rx_drop_cnt)
  );

  typedef struct packed {
    logic ready; logic [3:0] typ; logic tv; logic [53:0] key; logic kv;
    logic [47:0] ts4; logic ts4v; logic [47:0] t1; logic [47:0] t2; logic sv;
    logic [47:0] t4; logic rv;
    logic [CW-1:0] c_sync; logic [CW-1:0] c_req; logic [CW-1:0] c_resp;
    logic [CW-1:0] c_err; logic [CW-1:0] c_drop;
  } obs_t;

  obs_t m = '0;  // model state after the inputs of the current cycle
  obs_t e = '0;  // what the DUT must show now
  int   n_checks = 0;
  int   n_err = 0;

  // frame-level model state
  bit          open_f = 1'b0;
  bit          await_f = 1'b0;
  int          pos = 0;
  logic [5:0]  f_port;
  logic [47:0] f_ing, f_dmac, f_smac, f_org;
  logic [15:0] f_et, f_msg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) e <= '0;
    else        e <= m;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("in_ready", 64'(rx.in_ready), 64'(e.ready));
    check("ptp_rcv_type", 64'(ptp_rcv_type), 64'(e.typ));
    check("ptp_rcv_type_valid", 64'(ptp_rcv_type_valid), 64'(e.tv));
    check("key", 64'(key), 64'(e.key));
    check("key_valid", 64'(key_valid), 64'(e.kv));
    check("ts_4", 64'(ts_4), 64'(e.ts4));
    check("ts_4_valid", 64'(ts_4_valid), 64'(e.ts4v));
    check("t1_ts", 64'(t1_ts), 64'(e.t1));
    check("t2_ts", 64'(t2_ts), 64'(e.t2));
    check("sync_ts_valid", 64'(sync_ts_valid), 64'(e.sv));
    check("t4_ts", 64'(t4_ts), 64'(e.t4));
    check("resp_ts_valid", 64'(resp_ts_valid), 64'(e.rv));
    check("rx_sync_cnt", 64'(rx_sync_cnt), 64'(e.c_sync));
    check("rx_req_cnt", 64'(rx_req_cnt), 64'(e.c_req));
    check("rx_resp_cnt", 64'(rx_resp_cnt), 64'(e.c_resp));
    check("rx_err_cnt", 64'(rx_err_cnt), 64'(e.c_err));
    check("rx_drop_cnt", 64'(rx_drop_cnt), 64'(e.c_drop));
  end

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] x);
    return (x == {CW{1'b1}}) ? x : x + 1'b1;
  endfunction

  function automatic bit dmac_ok(input logic [47:0] d);
`ifdef PTP_RX_DMAC_FILTER_EN
    return (d == MY_MAC) || (d == BCAST);
`else
    return (d == d);
`endif
  endfunction

  task automatic evaluate(input logic v);
    if (!v) m.c_err = sat(m.c_err);
    else if (f_et == ET && dmac_ok(f_dmac) &&
             (f_msg == 16'h0101 || f_msg == 16'h0301 || f_msg == 16'h0401 ||
              f_msg == 16'h0501)) begin
      m.tv = 1'b1;
      case (f_msg)
        16'h0101: begin
          m.typ = 4'd1; m.key = {f_smac, f_port}; m.kv = 1'b1;
          m.t1 = f_org; m.t2 = f_ing; m.sv = 1'b1; m.c_sync = sat(m.c_sync);
        end
        16'h0301: begin
          m.typ = 4'd3; m.key = {f_smac, f_port}; m.kv = 1'b1;
          m.ts4 = f_ing; m.ts4v = 1'b1; m.c_req = sat(m.c_req);
        end
        16'h0401: begin
          m.typ = 4'd4; m.t4 = f_org; m.rv = 1'b1; m.c_resp = sat(m.c_resp);
        end
        default: m.typ = 4'd5;
      endcase
    end else m.c_drop = sat(m.c_drop);
  endtask

  // Frame rules: pos = flits accepted in the open frame; a complete frame awaits its status.
  task automatic model_step(input logic wr, input logic [133:0] d, input logic vwr,
                            input logic v);
    m.tv = 1'b0; m.kv = 1'b0; m.ts4v = 1'b0; m.sv = 1'b0; m.rv = 1'b0;
    if (wr) begin
      if (d[133:132] == 2'b01) begin
        if (open_f) m.c_err = sat(m.c_err);
        open_f = 1'b1; pos = 1; f_port = d[125:120]; f_ing = d[47:0];
      end else if (d[133:132] == 2'b11) begin
        if (!open_f || pos == PKT - 1) begin
          m.c_err = sat(m.c_err); open_f = 1'b0;
        end else begin
          if (pos == 2) {f_dmac, f_smac, f_et, f_msg} = d[127:0];
          pos++;
        end
      end else if (d[133:132] == 2'b10) begin
        if (!open_f || pos != PKT - 1) begin
          m.c_err = sat(m.c_err); open_f = 1'b0;
        end else begin
          f_org = d[95:48]; open_f = 1'b0; await_f = 1'b1;
        end
      end
    end
    if (vwr && await_f) begin
      await_f = 1'b0;
      evaluate(v);
    end
    m.ready = !await_f;
  endtask

  function automatic logic [133:0] junk();
    return {6'($urandom), $urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic logic [133:0] mk_head(input logic [5:0] p, input logic [47:0] ts);
    logic [133:0] r = junk();
    r[133:132] = 2'b01; r[125:120] = p; r[47:0] = ts;
    return r;
  endfunction
  function automatic logic [133:0] mk_mid();
    logic [133:0] r = junk();
    r[133:132] = 2'b11;
    return r;
  endfunction
  function automatic logic [133:0] mk_eth(input logic [47:0] dm, input logic [47:0] sm,
                                          input logic [15:0] et, input logic [15:0] msg);
    logic [133:0] r = junk();
    r[133:132] = 2'b11; r[127:0] = {dm, sm, et, msg};
    return r;
  endfunction
  function automatic logic [133:0] mk_tail(input logic [47:0] org);
    logic [133:0] r = junk();
    r[133:132] = 2'b10; r[95:48] = org;
    return r;
  endfunction

  task automatic slot(input logic wr, input logic [133:0] d, input logic vwr, input logic v);
    @(posedge clk); #1;
    rx.in_data_wr = wr; rx.in_data = d; rx.in_valid_wr = vwr; rx.in_valid = v;
    model_step(wr, d, vwr, v);
  endtask

  task automatic idle();
    slot(1'b0, junk(), 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [5:0] port, input logic [47:0] ing,
                            input logic [47:0] dmac, input logic [47:0] smac,
                            input logic [15:0] et, input logic [15:0] msg,
                            input logic [47:0] org, input logic v,
                            input int status_gap, input bit gaps);
    logic [133:0] f [PKT];
    f[0] = mk_head(port, ing);
    f[1] = mk_mid();
    f[2] = mk_eth(dmac, smac, et, msg);
    for (int i = 3; i < PKT - 1; i++) f[i] = mk_mid();
    f[PKT-1] = mk_tail(org);
    for (int i = 0; i < PKT; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle();
      slot(1'b1, f[i], (i == PKT - 1) && (status_gap == 0), v);
    end
    if (status_gap > 0) begin
      repeat (status_gap - 1) idle();
      slot(1'b0, junk(), 1'b1, v);
    end
  endtask

  task automatic rand_frame();
    logic [15:0] msg;
    logic [47:0] dmac;
    case ($urandom_range(0, 9))
      0, 1, 2: msg = 16'h0101;
      3, 4:    msg = 16'h0301;
      5, 6:    msg = 16'h0401;
      7:       msg = 16'h0501;
      8:       msg = 16'h0201;
      default: msg = 16'($urandom);
    endcase
    case ($urandom_range(0, 2))
      0:       dmac = MY_MAC;
      1:       dmac = BCAST;
      default: dmac = {16'($urandom), $urandom};
    endcase
    send_frame(6'($urandom), {16'($urandom), $urandom}, dmac, {16'($urandom), $urandom},
               ($urandom_range(0, 9) == 0) ? 16'h0800 : ET, msg, {16'($urandom), $urandom},
               $urandom_range(0, 7) != 0, $urandom_range(0, 3), 1'b1);
  endtask

  task automatic rand_error();
    int n;
    case ($urandom_range(0, 3))
      0: begin  // truncated; the next head aborts it
        slot(1'b1, mk_head(6'($urandom), 48'($urandom)), 1'b0, 1'b0);
        n = $urandom_range(0, 4);
        repeat (n) slot(1'b1, mk_mid(), 1'b0, 1'b0);
      end
      1: begin  // early tail
        slot(1'b1, mk_head(6'($urandom), 48'($urandom)), 1'b0, 1'b0);
        n = $urandom_range(0, 3);
        repeat (n) slot(1'b1, mk_mid(), 1'b0, 1'b0);
        slot(1'b1, mk_tail(48'($urandom)), 1'($urandom), 1'b1);
      end
      2: begin  // stray flit outside any frame
        if (!open_f)
          slot(1'b1, ($urandom_range(0, 1) == 0) ? mk_mid() : mk_tail(48'h0), 1'b0, 1'b0);
      end
      default: begin  // one mid too many, then an orphan tail
        slot(1'b1, mk_head(6'($urandom), 48'($urandom)), 1'b0, 1'b0);
        repeat (PKT - 1) slot(1'b1, mk_mid(), 1'b0, 1'b0);
        slot(1'b1, mk_tail(48'($urandom)), 1'b1, 1'b1);
      end
    endcase
    if (await_f) slot(1'b0, junk(), 1'b1, 1'b1);
  endtask

  task automatic model_reset();
    open_f = 1'b0; await_f = 1'b0; pos = 0; m = '0;
  endtask

  initial begin
    rx.in_data_wr = 1'b0; rx.in_data = '0; rx.in_valid_wr = 1'b0; rx.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lit_reset_ready", 64'(rx.in_ready), 64'h0);
    check("lit_reset_err", 64'(rx_err_cnt), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; m.ready = 1'b1;
    idle();
    @(negedge clk);
    check("lit_ready_after_reset", 64'(rx.in_ready), 64'h1);

    send_frame(6'd2, 48'h10, MY_MAC, 48'hA1A2A3A4A5A6, ET, 16'h0101, 48'h5, 1'b1, 1, 1'b0);
    idle(); @(negedge clk);
    check("lit_sync_type", 64'(ptp_rcv_type), 64'd1);
    check("lit_sync_t1", 64'(t1_ts), 64'h5);
    check("lit_sync_t2", 64'(t2_ts), 64'h10);
    check("lit_sync_key", 64'(key), {10'h0, 48'hA1A2A3A4A5A6, 6'd2});
    check("lit_sync_kv", 64'(key_valid), 64'h1);
    check("lit_sync_cnt", 64'(rx_sync_cnt), 64'd1);

    send_frame(6'd7, 48'h1234, MY_MAC, 48'hB1B2B3B4B5B6, ET, 16'h0301, 48'h99, 1'b1, 0, 1'b0);
    idle(); @(negedge clk);
    check("lit_req_ts4", 64'(ts_4), 64'h1234);
    check("lit_req_ts4v", 64'(ts_4_valid), 64'h1);
    check("lit_req_type", 64'(ptp_rcv_type), 64'd3);
    check("lit_req_cnt", 64'(rx_req_cnt), 64'd1);

    send_frame(6'd1, 48'h77, MY_MAC, 48'hC1C2C3C4C5C6, ET, 16'h0401, 48'hABCD, 1'b1, 2, 1'b0);
    idle(); @(negedge clk);
    check("lit_resp_t4", 64'(t4_ts), 64'hABCD);
    check("lit_resp_rv", 64'(resp_ts_valid), 64'h1);
    check("lit_resp_type", 64'(ptp_rcv_type), 64'd4);
    check("lit_resp_kv", 64'(key_valid), 64'h0);

    send_frame(6'd1, 48'h1, MY_MAC, 48'h1, 16'h0800, 16'h0101, 48'h2, 1'b1, 1, 1'b0);
    idle(); @(negedge clk);
    check("lit_etype_drop", 64'(rx_drop_cnt), 64'd1);
    check("lit_etype_tv", 64'(ptp_rcv_type_valid), 64'h0);
    send_frame(6'd1, 48'h1, MY_MAC, 48'h1, 16'h0800, 16'h0101, 48'h2, 1'b0, 1, 1'b0);
    idle(); @(negedge clk);
    check("lit_crc_err", 64'(rx_err_cnt), 64'd1);
    check("lit_crc_drop", 64'(rx_drop_cnt), 64'd1);

    slot(1'b1, mk_head(6'd3, 48'h3), 1'b0, 1'b0);
    slot(1'b1, mk_mid(), 1'b0, 1'b0);
    slot(1'b1, mk_mid(), 1'b0, 1'b0);
    send_frame(6'd4, 48'h40, MY_MAC, 48'hD1D2D3D4D5D6, ET, 16'h0101, 48'h41, 1'b1, 1, 1'b0);
    idle(); @(negedge clk);
    check("lit_len_err", 64'(rx_err_cnt), 64'd2);
    check("lit_len_sync_cnt", 64'(rx_sync_cnt), 64'd2);
    check("lit_len_t2", 64'(t2_ts), 64'h40);

    send_frame(6'd5, 48'h50, 48'h112233445566, 48'hE1, ET, 16'h0101, 48'h51, 1'b1, 1, 1'b0);
    idle(); @(negedge clk);
`ifdef PTP_RX_DMAC_FILTER_EN
    check("lit_dmac_drop", 64'(rx_drop_cnt), 64'd2);
    check("lit_dmac_sync", 64'(rx_sync_cnt), 64'd2);
`else
    check("lit_dmac_drop", 64'(rx_drop_cnt), 64'd1);
    check("lit_dmac_sync", 64'(rx_sync_cnt), 64'd3);
`endif
    send_frame(6'd6, 48'h60, BCAST, 48'hE2, ET, 16'h0101, 48'h61, 1'b1, 1, 1'b0);
    idle(); @(negedge clk);
`ifdef PTP_RX_DMAC_FILTER_EN
    check("lit_bcast_sync", 64'(rx_sync_cnt), 64'd3);
`else
    check("lit_bcast_sync", 64'(rx_sync_cnt), 64'd4);
`endif

    slot(1'b1, mk_head(6'd9, 48'h9), 1'b0, 1'b0);
    slot(1'b1, mk_mid(), 1'b0, 1'b0);
    slot(1'b1, mk_mid(), 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    rx.in_data_wr = 1'b0; rx.in_valid_wr = 1'b0; rx.in_valid = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check("lit_rst_sync_cnt", 64'(rx_sync_cnt), 64'd0);
    check("lit_rst_err_cnt", 64'(rx_err_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; m.ready = 1'b1;

    repeat (400) begin
      if ($urandom_range(0, 4) == 0) rand_error();
      else rand_frame();
    end
    repeat (3) idle();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
